// File: rtl/seq_event_bcd_counter_pkg.sv
// seq_pkg: constants shared by the BCD event counter and its decade cells.
//   BCD_W    - width of one packed BCD digit
//   BCD_MAX  - highest legal digit value (9)
//   BCD_ZERO - digit reset/clear value
package seq_pkg;

  localparam int         BCD_W    = 4;
  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

endpackage : seq_pkg

// File: rtl/seq_event_bcd_counter_bcd_decade.sv
// bcd_decade: one registered BCD digit (0..9) with ripple carry.
// Ports:
//   clk       - system clock
//   rst_n     - asynchronous active-low reset (digit -> 0)
//   clr       - synchronous clear (digit -> 0), wins over inc
//   inc       - increment request from the lower decade / accept logic
//   q[3:0]    - registered digit value
//   carry_out - inc & (q == 9): this digit rolls over into the next one
module bcd_decade
  import seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] q,
  output logic             carry_out
);

  logic [BCD_W-1:0] q_d;
  logic [BCD_W-1:0] q_q;

  // Next digit value: clear, roll 9 -> 0, or step by one.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = BCD_ZERO;
    end else if (inc) begin
      if (q_q == BCD_MAX) begin
        q_d = BCD_ZERO;
      end else begin
        q_d = q_q + 4'd1;
      end
    end else begin
      q_d = q_q;
    end
  end

  // Digit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= BCD_ZERO;
    end else begin
      q_q <= q_d;
    end
  end

  // Carry is combinational so a whole 0999 -> 1000 ripple settles in one cycle.
  assign carry_out = inc & (q_q == BCD_MAX);
  assign q         = q_q;

endmodule : bcd_decade

// File: rtl/seq_event_bcd_counter.sv
// seq_event_bcd_counter: counts rising edges of the sequence-detector level
// in a packed BCD counter of DIGITS decades.
// Parameters:
//   DIGITS   - number of BCD decades (1..8)
//   SATURATE - 0: wrap to all-zero past max, 1: hold at all-nines
// Ports:
//   clk       - system clock
//   rst_n     - asynchronous active-low reset
//   det_in    - detect level from the sequencer
//   en        - count enable; edges seen while low are dropped
//   clr       - synchronous clear of count and overflow (beats an event)
//   bcd_out   - packed BCD count, digit 0 (units) in bits [3:0]
//   evt_pulse - one-cycle registered pulse per accepted event
//   ovf       - sticky: an accepted event arrived at max count
module seq_event_bcd_counter
  import seq_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  det_in,
  input  logic                  en,
  input  logic                  clr,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  evt_pulse,
  output logic                  ovf
);

  logic              det_d, det_q;
  logic              evt_pulse_d, evt_pulse_q;
  logic              ovf_d, ovf_q;
  logic              evt_s;
  logic              acc_s;
  logic              at_max_s;
  logic              ovf_set_s;
  logic [DIGITS:0]   inc_chain_s;
  logic [DIGITS-1:0] digit_max_s;

  assign evt_s    = det_in & ~det_q;
  assign acc_s    = evt_s & en & ~clr;
  assign at_max_s = &digit_max_s;

  // In saturate mode the increment is suppressed at all-nines so the count holds.
  assign inc_chain_s[0] = acc_s & ~(SATURATE & at_max_s);

  // In wrap mode the carry out of the top decade is exactly "event at max".
  assign ovf_set_s = SATURATE ? (acc_s & at_max_s) : inc_chain_s[DIGITS];

  genvar k;
  generate
    for (k = 0; k < DIGITS; k++) begin : g_decade
      bcd_decade u_decade (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .inc       (inc_chain_s[k]),
        .q         (bcd_out[BCD_W*k +: BCD_W]),
        .carry_out (inc_chain_s[k+1])
      );
      assign digit_max_s[k] = (bcd_out[BCD_W*k +: BCD_W] == BCD_MAX);
    end
  endgenerate

  // Next-state for edge detector, event pulse and sticky overflow.
  always_comb begin
    det_d       = det_in;
    evt_pulse_d = acc_s;
    ovf_d       = ovf_q;
    if (clr) begin
      ovf_d = 1'b0;
    end else if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      det_q       <= 1'b0;
      evt_pulse_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      det_q       <= det_d;
      evt_pulse_q <= evt_pulse_d;
      ovf_q       <= ovf_d;
    end
  end

  assign evt_pulse = evt_pulse_q;
  assign ovf       = ovf_q;

endmodule : seq_event_bcd_counter
